// File: rtl/stream_xor_signature.sv
// AXI-Stream XOR-reduction sink: folds each beat to OUT_WIDTH bits and emits one signature per frame.
// Define XOR_SIGNATURE_ROTATE_EN for an order-sensitive (rotate-then-XOR) signature.
module stream_xor_signature #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH   = 8,
    parameter int unsigned FRAME_BEATS = 16,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [OUT_WIDTH-1:0]  m_axis_tdata,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [CNT_WIDTH-1:0]  frame_count
);

    localparam int unsigned NCH       = (DATA_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
    localparam int unsigned PAD_WIDTH = NCH * OUT_WIDTH;
    localparam int unsigned BCW       = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(FRAME_BEATS - 1);

    typedef enum logic {
        StAccum,
        StOutput
    } state_e;

    state_e                 state;
    logic [OUT_WIDTH-1:0]   acc;
    logic [OUT_WIDTH-1:0]   acc_next;
    logic [OUT_WIDTH-1:0]   fold;
    logic [PAD_WIDTH-1:0]   padded;
    logic [BCW-1:0]         beat_cnt;

    // Rotate left by one within OUT_WIDTH; degenerates to identity at width 1.
    function automatic logic [OUT_WIDTH-1:0] rotl1(input logic [OUT_WIDTH-1:0] a);
        logic [OUT_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < int'(OUT_WIDTH); i++) begin
            r[(i + 1) % int'(OUT_WIDTH)] = a[i];
        end
        return r;
    endfunction

    always_comb begin
        padded = '0;
        padded[DATA_WIDTH-1:0] = s_axis_tdata;
        fold = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            fold = fold ^ padded[k*OUT_WIDTH +: OUT_WIDTH];
        end
    end

    always_comb begin
`ifdef XOR_SIGNATURE_ROTATE_EN
        acc_next = rotl1(acc) ^ fold;
`else
        acc_next = acc ^ fold;
`endif
    end

    // Ready drops with rst itself so no beat is offered while reset is held.
    assign s_axis_tready = (state == StAccum) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StAccum;
            acc           <= '0;
            beat_cnt      <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            frame_count   <= '0;
        end else begin
            unique case (state)
                StAccum: begin
                    if (s_axis_tvalid) begin
                        if (beat_cnt == LAST_BEAT) begin
                            m_axis_tdata  <= acc_next;
                            m_axis_tuser  <= ^acc_next;
                            m_axis_tvalid <= 1'b1;
                            acc           <= '0;
                            beat_cnt      <= '0;
                            state         <= StOutput;
                        end else begin
                            acc      <= acc_next;
                            beat_cnt <= beat_cnt + BCW'(1);
                        end
                    end
                end
                StOutput: begin
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        frame_count   <= frame_count + CNT_WIDTH'(1);
                        state         <= StAccum;
                    end
                end
                default: state <= StAccum;
            endcase
        end
    end

endmodule
